// File: rtl/regfile_pkg.sv
// Shared constants for the 32-entry register file and its read ports.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/rf_read_port.sv
// One registered read port: output register, r0 forcing and write-through bypass.
// Optional feature: REGFILE_BYPASS_EN selects write-through on a same-cycle write/read hit.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_zero;

  assign rd_zero = (rd_addr == ADDR_W'(ZERO_REG));

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_zero) begin
        rd_data_d = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
`endif
      end else begin
        rd_data_d = rd_word;
      end
    end
  end

  // p0 -> p1: port output register
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regfile32.sv
// Two-read / one-write register file with r0 hardwired to zero and 1-cycle reads.
// Optional feature: REGFILE_BYPASS_EN (write-through bypass, passed to rf_read_port).
module regfile32
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataA,
  output logic [DATA_W-1:0] RdDataB,
  output logic              RdValid
);

  localparam int NumRegs = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_d [NumRegs];
  logic [DATA_W-1:0] mem_q [NumRegs];
  logic              rd_valid_d, rd_valid_q;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    mem_d = mem_q;
    if (WrEn && (WrAddr != ADDR_W'(ZERO_REG))) mem_d[WrAddr] = WrData;
  end

  assign rd_valid_d = RdEn;

  // p0 -> p1: storage and read-valid update
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_q      <= '{default: '0};
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RdValid = rd_valid_q;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .clk     (Clk),
    .rst     (Reset),
    .rd_en   (RdEn),
    .rd_addr (RdAddrA),
    .rd_word (mem_q[RdAddrA]),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .rd_data (RdDataA)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .clk     (Clk),
    .rst     (Reset),
    .rd_en   (RdEn),
    .rd_addr (RdAddrB),
    .rd_word (mem_q[RdAddrB]),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .rd_data (RdDataB)
  );

endmodule

// File: tb/tb_regfile32.sv
// Bench for regfile32: directed scenarios plus randomized traffic against an array model.
module tb_regfile32;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        WrEn = 1'b0;
  logic [4:0]  WrAddr = '0;
  logic [31:0] WrData = '0;
  logic        RdEn = 1'b0;
  logic [4:0]  RdAddrA = '0;
  logic [4:0]  RdAddrB = '0;
  logic [31:0] RdDataA, RdDataB;
  logic        RdValid;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [32];
  logic [31:0] exp_a = '0, exp_b = '0;
  logic        exp_vld = 1'b0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regfile32 dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .RdEn    (RdEn),
    .RdAddrA (RdAddrA),
    .RdAddrB (RdAddrB),
    .RdDataA (RdDataA),
    .RdDataB (RdDataB),
    .RdValid (RdValid)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] read_model(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 0) return 32'h0;
    if (Bypass && we && wa == ra) return wd;
    return model_mem[ra];
  endfunction

  // One clock: drive on the falling edge, update the model at the rising edge, check after it.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] ra, input logic [4:0] rb,
                      input string tag);
    @(negedge Clk);
    Reset = rst; WrEn = we; WrAddr = wa; WrData = wd;
    RdEn = re; RdAddrA = ra; RdAddrB = rb;
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      exp_a = '0; exp_b = '0; exp_vld = 1'b0;
    end else begin
      if (re) begin
        exp_a = read_model(ra, we, wa, wd);
        exp_b = read_model(rb, we, wa, wd);
      end
      exp_vld = re;
      if (we && wa != 0) model_mem[wa] = wd;
    end
    #1;
    check({tag, ".a"}, RdDataA, exp_a);
    check({tag, ".b"}, RdDataB, exp_b);
    check({tag, ".vld"}, {31'b0, RdValid}, {31'b0, exp_vld});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = '0;

    step(1, 0, 0, 0, 0, 0, 0, "reset0");
    step(1, 0, 0, 0, 0, 0, 0, "reset1");

    // Reset clears a freshly written register
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, "wr_r5");
    step(1, 0, 0, 0, 0, 0, 0, "rst_after_wr");
    step(0, 0, 0, 0, 1, 5, 5, "rd_r5_after_rst");

    // r0 is immutable
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, "wr_r0");
    step(0, 0, 0, 0, 1, 0, 0, "rd_r0");

    // Two distinct registers on A and B
    step(0, 1, 3, 32'h12345678, 0, 0, 0, "wr_r3");
    step(0, 1, 31, 32'h0000000F, 0, 0, 0, "wr_r31");
    step(0, 0, 0, 0, 1, 3, 31, "rd_r3_r31");

    // Same-cycle write/read of r7
    step(0, 1, 7, 32'h1, 0, 0, 0, "wr_r7_1");
    step(0, 1, 7, 32'h2, 1, 7, 7, "wr_rd_r7");
    step(0, 0, 0, 0, 1, 7, 3, "rd_r7_next");

    // Outputs hold while RdEn is low
    step(0, 0, 0, 0, 1, 3, 3, "rd_r3_prev");
    for (int i = 0; i < 4; i++)
      step(0, 1, 3, 32'hAAAA5555, 0, 5'(i), 5'(i + 1), "hold");
    step(0, 0, 0, 0, 1, 3, 3, "rd_r3_new");

    // Reset beats a coincident write
    step(0, 1, 9, 32'h11, 0, 0, 0, "wr_r9");
    step(1, 1, 9, 32'h55, 1, 9, 9, "rst_wr_r9");
    step(0, 0, 0, 0, 1, 9, 9, "rd_r9");

    // Back-to-back writes to one address, last wins; operations on the first edge after reset
    step(0, 1, 12, 32'hA, 0, 0, 0, "wr12_a");
    step(0, 1, 12, 32'hB, 0, 0, 0, "wr12_b");
    step(0, 1, 12, 32'hC, 1, 12, 0, "wr12_c");
    step(0, 0, 0, 0, 1, 12, 12, "rd12");

    // Randomized traffic on a narrow address window to force collisions
    for (int n = 0; n < 500; n++) begin
      logic [4:0] base;
      base = (n < 250) ? 5'd0 : 5'd24;
      step(($urandom_range(0, 49) == 0),
           1'($urandom), base + 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) != 0),
           base + 5'($urandom_range(0, 7)), base + 5'($urandom_range(0, 7)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile32.md
REGFILE32 -- requirements
Module: regfile32

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (2**ADDR_W registers).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port WrEn  input  1  write strobe, sampled each Clk edge.
REQ-006 SHALL have port WrAddr  input  ADDR_W  destination register (driven by the rt/rd 5-bit select mux).
REQ-007 SHALL have port WrData  input  DATA_W  write-back data.
REQ-008 SHALL have port RdEn  input  1  capture strobe for both read ports.
REQ-009 SHALL have port RdAddrA  input  ADDR_W  port A source register (rs).
REQ-010 SHALL have port RdAddrB  input  ADDR_W  port B source register (rt).
REQ-011 SHALL have port RdDataA  output  DATA_W  registered port A value.
REQ-012 SHALL have port RdDataB  output  DATA_W  registered port B value.
REQ-013 SHALL have port RdValid  output  1  high one cycle after a cycle with RdEn=1, else low.

Function
REQ-014 SHALL store 2**ADDR_W registers of DATA_W bits each.
REQ-015 SHALL write WrData to register WrAddr at the Clk edge where WrEn=1 and Reset=0.
REQ-016 SHALL ignore writes to address 0; register 0 reads as 0 at all times.
REQ-017 SHALL, on a Clk edge with RdEn=1, load RdDataA/RdDataB from RdAddrA/RdAddrB (1-cycle latency).
REQ-018 SHALL hold RdDataA/RdDataB unchanged when RdEn=0.
REQ-019 SHALL return the same value on both ports when RdAddrA==RdAddrB.
REQ-020 SHALL handle same-cycle write/read of the same nonzero address per REQ-025/REQ-026.
REQ-021 SHALL complete multiple consecutive writes to one address in order; the last write wins.

Reset
REQ-022 SHALL, on a Clk edge with Reset=1, clear all registers, RdDataA, RdDataB and RdValid to 0.
REQ-023 SHALL give Reset priority over WrEn and RdEn in the same cycle; the write is dropped.
REQ-024 SHALL accept a write or read on the first edge after Reset deasserts.

Configuration
REQ-025 SHALL, with REGFILE_BYPASS_EN defined, capture WrData into a read port when WrEn=1, RdEn=1, WrAddr==RdAddrX!=0 in the same cycle (write-through bypass).
REQ-026 SHALL, without REGFILE_BYPASS_EN, capture the pre-write register contents in that case; the new value is visible on the next read.

Structure
REQ-027 SHALL take DATA_W, ADDR_W, NUM_REGS and ZERO_REG constants from shared package regfile_pkg.
REQ-028 SHALL implement each read port as sub-module rf_read_port, instantiated twice (A, B); it holds the output register, zero-address forcing and bypass compare.

Verification
REQ-029 SHALL cover: Reset=1 one cycle after writing 0xDEADBEEF to r5 -> RdEn on r5 yields RdDataA=0, RdValid=1 next cycle.
REQ-030 SHALL cover: WrEn, WrAddr=0, WrData=0xFFFFFFFF, then read r0 on A and B -> both 0x00000000.
REQ-031 SHALL cover: write r3=0x12345678, r31=0x0000000F; read A=r3, B=r31 -> 0x12345678 / 0x0000000F one cycle after RdEn.
REQ-032 SHALL cover: r7=0x1 stored; same cycle WrEn r7=0x2 and RdEn A=r7 -> RdDataA=0x2 with REGFILE_BYPASS_EN, 0x1 without; next read 0x2 either way.
REQ-033 SHALL cover: RdEn=0 for 4 cycles while r3 is rewritten to 0xAAAA5555 -> RdDataA holds previous value, RdValid=0.
REQ-034 SHALL cover: Reset=1 coincident with WrEn r9=0x55 -> later read of r9 returns 0.
